aqp_audio_fifo: RTL and testbench

//  Stereo sample buffer and sample-rate pacer feeding aqp_pwm_dac. The core writes packed
//  L/R 16-bit samples at its own pace; the block releases one sample per sample period.
//  Its outputs drive left_data/right_data and next_sample of the DAC.

---
 rtl/aqp_audio_fifo.sv | 149 ++++++++++++++
 tb/tb_aqp_audio_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aqp_audio_fifo.sv
// Stereo sample FIFO with a fixed-rate pacer that releases one L/R sample per period
// to the PWM DAC, plus sticky overflow/underflow status and a low-water interrupt.
module aqp_audio_fifo #(
    parameter int ADDR_W = 6,
    parameter int DIV    = 649
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic [31:0]       wr_data,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   lowwater,
    input  logic              clr_status,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              irq,
    output logic [15:0]       audio_l,
    output logic [15:0]       audio_r,
    output logic              sample_stb
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam int                DIV_W      = $clog2(DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEVEL_ZERO = (ADDR_W + 1)'(0);

    logic [31:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_r;
    logic [ADDR_W-1:0]  rd_ptr_r;
    logic [ADDR_W:0]    level_r;
    logic [ADDR_W:0]    level_next_s;
    logic [DIV_W-1:0]   div_r;
    logic [DIV_W-1:0]   div_next_s;
    logic               full_r;
    logic               overflow_r;
    logic               underflow_r;
    logic               irq_r;
    logic               stb_r;
    logic [15:0]        audio_l_r;
    logic [15:0]        audio_r_r;
    logic               tick_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;
    logic               empty_tick_s;

    // Pacer tick, push/pop qualification and next-state level/divider.
    // full is the registered value, so a push while full is dropped even if a pop
    // frees a slot in the same cycle; flush beats both push and pop.
    always_comb begin
        tick_s       = enable && (div_r == DIV_LAST);
        drop_s       = wr_en && full_r;
        push_s       = wr_en && !full_r && !flush;
        pop_s        = tick_s && (level_r != LEVEL_ZERO) && !flush;
        empty_tick_s = tick_s && (level_r == LEVEL_ZERO);

        if (!enable) begin
            div_next_s = DIV_W'(0);
        end else if (tick_s) begin
            div_next_s = DIV_W'(0);
        end else begin
            div_next_s = div_r + DIV_W'(1);
        end

        if (flush) begin
            level_next_s = LEVEL_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_next_s = level_r + (ADDR_W + 1)'(1);
                2'b01:   level_next_s = level_r - (ADDR_W + 1)'(1);
                default: level_next_s = level_r;
            endcase
        end
    end

    // Sample storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, level, status, pacer and DAC-facing output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= ADDR_W'(0);
            rd_ptr_r    <= ADDR_W'(0);
            level_r     <= LEVEL_ZERO;
            full_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            irq_r       <= 1'b0;
            stb_r       <= 1'b0;
            audio_l_r   <= 16'h0000;
            audio_r_r   <= 16'h0000;
            div_r       <= DIV_W'(0);
        end else begin
            if (flush) begin
                wr_ptr_r <= ADDR_W'(0);
                rd_ptr_r <= ADDR_W'(0);
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
                end
            end

            if (pop_s) begin
                audio_l_r <= mem_r[rd_ptr_r][31:16];
                audio_r_r <= mem_r[rd_ptr_r][15:0];
            end

            // A set event in the same cycle as clr_status keeps the bit set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_status) begin
                overflow_r <= 1'b0;
            end

            if (empty_tick_s) begin
                underflow_r <= 1'b1;
            end else if (clr_status) begin
                underflow_r <= 1'b0;
            end

            level_r <= level_next_s;
            full_r  <= (level_next_s == LEVEL_FULL);
            irq_r   <= enable && (level_next_s <= lowwater);
            stb_r   <= tick_s;
            div_r   <= div_next_s;
        end
    end

    assign level      = level_r;
    assign full       = full_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;
    assign irq        = irq_r;
    assign audio_l    = audio_l_r;
    assign audio_r    = audio_r_r;
    assign sample_stb = stb_r;

endmodule

// File: tb/tb_aqp_audio_fifo.sv
// Directed bench for aqp_audio_fifo: vector table for the fill/overflow/clear phase
// plus hand-written sequences around pacer ticks, irq, flush and reset.
module tb_aqp_audio_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [6:0]  lowwater;
    logic        clr_status;
    logic [6:0]  level;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic        irq;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        sample_stb;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr_en;
        logic        clr;
        logic [31:0] data;
        logic [6:0]  exp_level;
        logic        exp_full;
        logic        exp_ovf;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [5];

    aqp_audio_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .lowwater   (lowwater),
        .clr_status (clr_status),
        .level      (level),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow),
        .irq        (irq),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .sample_stb (sample_stb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until sample_stb is seen; n is the number of edges taken (bounded).
    task automatic wait_stb(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_stb && n < 2000);
    endtask

    initial begin
        int n;

        vecs[0] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 7'd64, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 7'd64, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0000, 7'd64, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'hCAFE_F00D, 7'd64, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 7'd64, 1'b1, 1'b0, 1'b0};

        // Reset with busy inputs: reset must win.
        reset = 1'b1; enable = 1'b1; flush = 1'b0; wr_en = 1'b1;
        wr_data = 32'h5A5A_5A5A; lowwater = 7'd0; clr_status = 1'b0;
        idle(3);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_audio", {audio_l, audio_r}, 32'h0000_0000);
        chk("rst_stb", 32'(sample_stb), 32'd0);

        // Empty FIFO with pacer running: stb every 649 cycles, underflow, audio stays 0.
        wr_en = 1'b0;
        reset = 1'b0;
        wait_stb(n);
        chk("t1_first_period", 32'(n), 32'd649);
        chk("t1_audio", {audio_l, audio_r}, 32'h0000_0000);
        chk("t1_unf", 32'(underflow), 32'd1);
        chk("t1_irq", 32'(irq), 32'd1);
        step();
        chk("t1_stb_width", 32'(sample_stb), 32'd0);
        wait_stb(n);
        chk("t1_second_period", 32'(n), 32'd648);

        // Two samples out in order.
        clr_status = 1'b1; step(); clr_status = 1'b0;
        chk("t2_unf_clr", 32'(underflow), 32'd0);
        push(32'h1234_ABCD);
        push(32'h0001_FFFF);
        chk("t2_level2", 32'(level), 32'd2);
        wait_stb(n);
        chk("t2_gap1", 32'(n), 32'd646);
        chk("t2_audio1", {audio_l, audio_r}, 32'h1234_ABCD);
        chk("t2_level1", 32'(level), 32'd1);
        wait_stb(n);
        chk("t2_gap2", 32'(n), 32'd649);
        chk("t2_audio2", {audio_l, audio_r}, 32'h0001_FFFF);
        chk("t2_level0", 32'(level), 32'd0);
        chk("t2_unf", 32'(underflow), 32'd0);

        // Low-water irq around level 8/9.
        lowwater = 7'd8;
        for (int k = 0; k < 9; k++) begin
            push(32'h1100_2200 + 32'(k) * 32'h0001_0001);
            if (k == 7) chk("t5_irq_at8", 32'(irq), 32'd1);
        end
        chk("t5_irq_at9", 32'(irq), 32'd0);
        wait_stb(n);
        chk("t5_gap", 32'(n), 32'd640);
        chk("t5_level8", 32'(level), 32'd8);
        chk("t5_irq_pop", 32'(irq), 32'd1);
        chk("t5_audio", {audio_l, audio_r}, 32'h1100_2200);
        push(32'h1109_2209);
        chk("t5_irq_repush", 32'(irq), 32'd0);
        push(32'h110A_220A);
        chk("t6_level10", 32'(level), 32'd10);

        // Flush beats a same-cycle push; next tick underflows and audio holds.
        flush = 1'b1; wr_en = 1'b1; wr_data = 32'hBAD0_BAD0;
        step();
        flush = 1'b0; wr_en = 1'b0;
        chk("t6_flush_level", 32'(level), 32'd0);
        chk("t6_flush_irq", 32'(irq), 32'd1);
        wait_stb(n);
        chk("t6_gap", 32'(n), 32'd646);
        chk("t6_unf", 32'(underflow), 32'd1);
        chk("t6_audio_hold", {audio_l, audio_r}, 32'h1100_2200);
        chk("t6_level_after", 32'(level), 32'd0);

        // Push into empty FIFO on the tick cycle: underflow, entry kept.
        clr_status = 1'b1; step(); clr_status = 1'b0;
        chk("tp_unf_clr", 32'(underflow), 32'd0);
        idle(647);
        push(32'h7777_8888);
        chk("tp_stb", 32'(sample_stb), 32'd1);
        chk("tp_unf", 32'(underflow), 32'd1);
        chk("tp_level", 32'(level), 32'd1);
        chk("tp_audio_hold", {audio_l, audio_r}, 32'h1100_2200);
        wait_stb(n);
        chk("tp_gap", 32'(n), 32'd649);
        chk("tp_audio", {audio_l, audio_r}, 32'h7777_8888);
        chk("tp_level0", 32'(level), 32'd0);

        // Pacer held: fill to 64, then table of overflow / clear cases.
        enable = 1'b0; clr_status = 1'b1; step(); clr_status = 1'b0;
        chk("t3_irq_disabled", 32'(irq), 32'd0);
        chk("t3_unf_clr", 32'(underflow), 32'd0);
        for (int i = 0; i < 64; i++) begin
            push(32'hA000_0000 + 32'(i));
            chk($sformatf("t3_fill%0d", i), 32'(level), 32'(i + 1));
        end
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_ovf_none", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wr_en      = vecs[i].wr_en;
            clr_status = vecs[i].clr;
            wr_data    = vecs[i].data;
            step();
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            chk($sformatf("vec%0d_stb", i), 32'(sample_stb), 32'd0);
        end
        wr_en = 1'b0; clr_status = 1'b0;

        // Full FIFO, push on the tick cycle: dropped, one pop.
        enable = 1'b1;
        idle(648);
        push(32'h5555_5555);
        chk("t4_stb", 32'(sample_stb), 32'd1);
        chk("t4_level63", 32'(level), 32'd63);
        chk("t4_full", 32'(full), 32'd0);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_audio", {audio_l, audio_r}, 32'hA000_0000);
        wait_stb(n);
        chk("t4_audio2", {audio_l, audio_r}, 32'hA000_0001);
        chk("t4_level62", 32'(level), 32'd62);

        // Reset mid-period restarts the divider.
        idle(300);
        reset = 1'b1;
        idle(2);
        chk("rm_level", 32'(level), 32'd0);
        chk("rm_ovf", 32'(overflow), 32'd0);
        chk("rm_audio", {audio_l, audio_r}, 32'h0000_0000);
        chk("rm_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        wait_stb(n);
        chk("rm_period", 32'(n), 32'd649);
        chk("rm_unf", 32'(underflow), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
